// File: rtl/sd_frame_loader.sv
// sd_frame_loader
//   Streams an RGB332 image (one byte per pixel, row-major) out of consecutive SD
//   sectors, packs PIX_PER_WORD pixels per BRAM word and writes them into a frame
//   BRAM. Independently converts the VGA (x, y) position into a BRAM read address
//   and turns the returned word into an RGB444 colour.
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   start, imno                 load request pulse and image index
//   busy, loaded                load in progress / complete image present
//   sd_ready_for_read, sd_byte_available, sd_byte   status and data from sd_controller
//   sd_rd, sd_address           sector read request towards sd_controller
//   wr_en, wr_addr, wr_data     BRAM write port (one packed word per pulse)
//   x, y, rd_addr, rd_data      VGA position, BRAM read address, BRAM read data
//   red, green, blue            registered RGB444 pixel colour
module sd_frame_loader #(
  parameter int IMG_W        = 320,
  parameter int IMG_H        = 240,
  parameter int PIX_PER_WORD = 4,
  parameter int BASE_SECTOR  = 0,
  parameter int SCALE_SHIFT  = 1,
  parameter int FLIP_Y       = 1,
  parameter int IMNO_W       = 2,
  localparam int AW = $clog2(IMG_W * IMG_H / PIX_PER_WORD),
  localparam int DW = 8 * PIX_PER_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IMNO_W-1:0] imno,
  output logic              busy,
  output logic              loaded,
  input  logic              sd_ready_for_read,
  input  logic              sd_byte_available,
  input  logic [7:0]        sd_byte,
  output logic              sd_rd,
  output logic [31:0]       sd_address,
  output logic              wr_en,
  output logic [AW-1:0]     wr_addr,
  output logic [DW-1:0]     wr_data,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  output logic [AW-1:0]     rd_addr,
  input  logic [DW-1:0]     rd_data,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue
);

  localparam int BYTES = IMG_W * IMG_H;
  localparam int SPI   = (BYTES + 511) / 512;
  localparam int WPR   = IMG_W / PIX_PER_WORD;
  localparam int LW    = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_RDY = 3'd1,
    S_REQ      = 3'd2,
    S_RECV     = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [IMNO_W-1:0] imno_r, imno_nxt_s;
  logic [31:0]       sector_r, sector_nxt_s;
  logic [31:0]       gidx_r, gidx_nxt_s;
  logic [31:0]       sd_addr_r, sd_addr_nxt_s;
  logic [8:0]        byte_cnt_r, byte_cnt_nxt_s;
  logic              busy_r, busy_nxt_s;
  logic              loaded_r, loaded_nxt_s;
  logic              sd_rd_r, sd_rd_nxt_s;
  logic              avail_prev_r;
  logic              byte_rise_s, byte_take_s, start_s;

  logic [DW-1:0]     shift_r;
  logic [LW-1:0]     lane_cnt_r;
  logic [AW-1:0]     word_cnt_r;
  logic              wr_en_r;
  logic [AW-1:0]     wr_addr_r;
  logic [DW-1:0]     wr_data_r;

  logic [9:0]        px_s, py_s;
  logic [31:0]       row_s;
  logic              in_range_s, in_range_r;
  logic [LW-1:0]     lane_s, lane_r;
  logic [7:0]        pix_s;
  logic [3:0]        red_r, green_r, blue_r;

  // Lane 0 sits in the most significant byte of the word.
  function automatic logic [7:0] pick_byte(input logic [DW-1:0] word, input logic [LW-1:0] lane);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < PIX_PER_WORD; i++) begin
      if (LW'(i) == lane) begin
        b = word[(PIX_PER_WORD - 1 - i) * 8 +: 8];
      end
    end
    return b;
  endfunction

  assign busy       = busy_r;
  assign loaded     = loaded_r;
  assign sd_rd      = sd_rd_r;
  assign sd_address = sd_addr_r;
  assign wr_en      = wr_en_r;
  assign wr_addr    = wr_addr_r;
  assign wr_data    = wr_data_r;
  assign red        = red_r;
  assign green      = green_r;
  assign blue       = blue_r;

  // sd_byte_available is a level; a new byte is its 0->1 transition.
  assign byte_rise_s = sd_byte_available & ~avail_prev_r;
  assign start_s     = (state_r == S_IDLE) && start;
  // Bytes beyond the image in the last sector are counted but never packed.
  assign byte_take_s = (state_r == S_RECV) && byte_rise_s && (gidx_r < 32'(BYTES));

  // Load FSM: next state and next values of all FSM-owned registers.
  always_comb begin
    state_nxt_s    = state_r;
    imno_nxt_s     = imno_r;
    sector_nxt_s   = sector_r;
    gidx_nxt_s     = gidx_r;
    sd_addr_nxt_s  = sd_addr_r;
    byte_cnt_nxt_s = byte_cnt_r;
    busy_nxt_s     = busy_r;
    loaded_nxt_s   = loaded_r;
    sd_rd_nxt_s    = sd_rd_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          imno_nxt_s     = imno;
          sector_nxt_s   = 32'd0;
          gidx_nxt_s     = 32'd0;
          byte_cnt_nxt_s = 9'd0;
          busy_nxt_s     = 1'b1;
          loaded_nxt_s   = 1'b0;
          state_nxt_s    = S_WAIT_RDY;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_WAIT_RDY: begin
        if (sd_ready_for_read) begin
          sd_addr_nxt_s = 32'(BASE_SECTOR) + 32'(imno_r) * 32'(SPI) + sector_r;
          sd_rd_nxt_s   = 1'b1;
          state_nxt_s   = S_REQ;
        end else begin
          state_nxt_s = S_WAIT_RDY;
        end
      end
      S_REQ: begin
        // The controller drops ready once it has taken the request.
        if (!sd_ready_for_read) begin
          sd_rd_nxt_s = 1'b0;
          state_nxt_s = S_RECV;
        end else begin
          sd_rd_nxt_s = 1'b1;
          state_nxt_s = S_REQ;
        end
      end
      S_RECV: begin
        if (byte_rise_s) begin
          byte_cnt_nxt_s = byte_cnt_r + 9'd1;
          gidx_nxt_s     = gidx_r + 32'd1;
          if (byte_cnt_r == 9'd511) begin
            sector_nxt_s = sector_r + 32'd1;
            if (sector_r + 32'd1 == 32'(SPI)) begin
              state_nxt_s = S_DONE;
            end else begin
              state_nxt_s = S_WAIT_RDY;
            end
          end else begin
            state_nxt_s = S_RECV;
          end
        end else begin
          state_nxt_s = S_RECV;
        end
      end
      S_DONE: begin
        busy_nxt_s   = 1'b0;
        loaded_nxt_s = 1'b1;
        state_nxt_s  = S_IDLE;
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // Load FSM state and control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      imno_r       <= '0;
      sector_r     <= 32'd0;
      gidx_r       <= 32'd0;
      sd_addr_r    <= 32'd0;
      byte_cnt_r   <= 9'd0;
      busy_r       <= 1'b0;
      loaded_r     <= 1'b0;
      sd_rd_r      <= 1'b0;
      avail_prev_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      imno_r       <= imno_nxt_s;
      sector_r     <= sector_nxt_s;
      gidx_r       <= gidx_nxt_s;
      sd_addr_r    <= sd_addr_nxt_s;
      byte_cnt_r   <= byte_cnt_nxt_s;
      busy_r       <= busy_nxt_s;
      loaded_r     <= loaded_nxt_s;
      sd_rd_r      <= sd_rd_nxt_s;
      avail_prev_r <= sd_byte_available;
    end
  end

  // Pixel packing: first byte ends up in the MSBs; a full word is written the cycle after its last byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_r    <= '0;
      lane_cnt_r <= '0;
      word_cnt_r <= '0;
      wr_en_r    <= 1'b0;
      wr_addr_r  <= '0;
      wr_data_r  <= '0;
    end else begin
      wr_en_r <= 1'b0;
      if (start_s) begin
        lane_cnt_r <= '0;
        word_cnt_r <= '0;
      end else if (byte_take_s) begin
        shift_r <= DW'({shift_r, sd_byte});
        if (lane_cnt_r == LW'(PIX_PER_WORD - 1)) begin
          wr_en_r    <= 1'b1;
          wr_data_r  <= DW'({shift_r, sd_byte});
          wr_addr_r  <= word_cnt_r;
          word_cnt_r <= word_cnt_r + AW'(1);
          lane_cnt_r <= '0;
        end else begin
          lane_cnt_r <= lane_cnt_r + LW'(1);
        end
      end
    end
  end

  assign px_s = x >> SCALE_SHIFT;
  assign py_s = y >> SCALE_SHIFT;

  // Readout address decode; out-of-range positions may wrap, the colour stage blanks them.
  always_comb begin
    in_range_s = (32'(px_s) < 32'(IMG_W)) && (32'(py_s) < 32'(IMG_H));
    if (FLIP_Y != 0) begin
      row_s = 32'(IMG_H - 1) - 32'(py_s);
    end else begin
      row_s = 32'(py_s);
    end
    rd_addr = AW'(row_s * 32'(WPR) + 32'(px_s) / 32'(PIX_PER_WORD));
    lane_s  = LW'(32'(px_s) % 32'(PIX_PER_WORD));
    pix_s   = pick_byte(rd_data, lane_r);
  end

  // Colour pipeline: lane and range flag align with rd_data, then RGB332 -> RGB444.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_r     <= '0;
      in_range_r <= 1'b0;
      red_r      <= 4'hF;
      green_r    <= 4'hF;
      blue_r     <= 4'hF;
    end else begin
      lane_r     <= lane_s;
      in_range_r <= in_range_s;
      if (!loaded_r) begin
        red_r   <= 4'hF;
        green_r <= 4'hF;
        blue_r  <= 4'hF;
      end else if (!in_range_r) begin
        red_r   <= 4'h0;
        green_r <= 4'h0;
        blue_r  <= 4'h0;
      end else begin
        red_r   <= {pix_s[7:5], 1'b0};
        green_r <= {pix_s[4:2], 1'b0};
        blue_r  <= {pix_s[1:0], 2'b00};
      end
    end
  end

endmodule

// File: tb/tb_sd_frame_loader.sv
// Testbench for sd_frame_loader: a small 32x20 image (2 sectors, partial last
// sector) is served by a behavioural SD model with random data and handshake
// timing; BRAM writes and the colour readout are checked against a byte-level
// image model.
module tb_sd_frame_loader;

  localparam int W     = 32;
  localparam int H     = 20;
  localparam int PPW   = 4;
  localparam int BASE  = 5;
  localparam int SH    = 1;
  localparam int FLIP  = 1;
  localparam int IW    = 2;
  localparam int BYTES = W * H;
  localparam int SPI   = (BYTES + 511) / 512;
  localparam int WORDS = BYTES / PPW;
  localparam int AW    = $clog2(WORDS);
  localparam int DW    = 8 * PPW;

  logic          clk;
  logic          rst;
  logic          start;
  logic [IW-1:0] imno;
  logic          busy, loaded;
  logic          sd_ready_for_read, sd_byte_available;
  logic [7:0]    sd_byte;
  logic          sd_rd;
  logic [31:0]   sd_address;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [9:0]    x, y;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [3:0]    red, green, blue;

  sd_frame_loader #(
    .IMG_W(W), .IMG_H(H), .PIX_PER_WORD(PPW), .BASE_SECTOR(BASE),
    .SCALE_SHIFT(SH), .FLIP_Y(FLIP), .IMNO_W(IW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .imno(imno), .busy(busy), .loaded(loaded),
    .sd_ready_for_read(sd_ready_for_read), .sd_byte_available(sd_byte_available),
    .sd_byte(sd_byte), .sd_rd(sd_rd), .sd_address(sd_address),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .x(x), .y(y), .rd_addr(rd_addr), .rd_data(rd_data),
    .red(red), .green(green), .blue(blue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame BRAM: write port from the loader, 1-cycle-latency read port.
  logic [DW-1:0] bram [2**AW];
  always @(posedge clk) begin
    if (wr_en) bram[wr_addr] <= wr_data;
    rd_data <= bram[rd_addr];
  end

  // Write log.
  logic [AW-1:0] wlog_addr [$];
  logic [DW-1:0] wlog_data [$];
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wlog_addr.push_back(wr_addr);
      wlog_data.push_back(wr_data);
    end
  end

  logic [7:0]  img_q [$];
  logic [7:0]  ref_img [BYTES];
  bit          model_loaded;
  logic [7:0]  pat [4];
  logic [11:0] dir_exp [4];
  int          n_cmp, n_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [11:0] ref_rgb(input int xx, input int yy);
    int px, py, row;
    logic [7:0] b;
    if (!model_loaded) return 12'hFFF;
    px = xx >> SH;
    py = yy >> SH;
    if (px >= W || py >= H) return 12'h000;
    row = (FLIP != 0) ? (H - 1 - py) : py;
    b = ref_img[row * W + px];
    return {b[7:5], 1'b0, b[4:2], 1'b0, b[1:0], 2'b00};
  endfunction

  // One new position per cycle; each result is expected exactly two cycles later.
  task automatic run_pixels(input int n, input bit directed);
    logic [11:0] exq [$];
    int xx, yy;
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        if (directed) begin
          xx = 2 * i; yy = 38;
          exq.push_back(dir_exp[i]);
        end else begin
          xx = $urandom_range(0, 79); yy = $urandom_range(0, 47);
          exq.push_back(ref_rgb(xx, yy));
        end
        x = 10'(xx); y = 10'(yy);
      end
      tick(1);
      if (i >= 1) chk("pixel_rgb", {red, green, blue}, exq[i-1]);
    end
  endtask

  task automatic pulse_start(input int img);
    wlog_addr.delete(); wlog_data.delete();
    imno = IW'(img); start = 1'b1; tick(1); start = 1'b0;
    imno = IW'($urandom);
    chk("busy_after_start", busy, 1);
    chk("loaded_after_start", loaded, 0);
  endtask

  task automatic serve_sector(input int img, input int s, input bit pattern, input bit poke, input int nbytes);
    int t, gi;
    logic [31:0] ea;
    logic [7:0] v;
    t = 0;
    while (sd_rd !== 1'b1 && t < 100) begin tick(1); t++; end
    chk("sd_rd_request", sd_rd, 1);
    ea = 32'(BASE + img * SPI + s);
    chk("sd_address", sd_address, ea);
    if (poke) begin
      imno = IW'(img ^ 1); start = 1'b1; tick(1); start = 1'b0;
      chk("busy_ignore_start", busy, 1);
      chk("addr_ignore_start", sd_address, ea);
    end
    repeat (3) begin
      tick(1);
      chk("sd_rd_hold", sd_rd, 1);
      chk("sd_address_hold", sd_address, ea);
    end
    sd_ready_for_read = 1'b0;
    tick(1);
    chk("sd_rd_drop", sd_rd, 0);
    for (int b = 0; b < nbytes; b++) begin
      gi = s * 512 + b;
      v = 8'($urandom);
      if (pattern && gi < 4) v = pat[gi];
      if (gi < BYTES) img_q.push_back(v);
      sd_byte = v; sd_byte_available = 1'b1; tick($urandom_range(1, 2));
      sd_byte_available = 1'b0; tick($urandom_range(1, 2));
    end
    if (nbytes == 512) sd_ready_for_read = 1'b1;
  endtask

  task automatic serve_load(input int img, input bit pattern, input bit poke);
    int t, nw;
    logic [DW-1:0] ew;
    img_q.delete();
    for (int s = 0; s < SPI; s++) serve_sector(img, s, pattern, poke && (s == 0), 512);
    t = 0;
    while (loaded !== 1'b1 && t < 50) begin tick(1); t++; end
    chk("loaded_done", loaded, 1);
    chk("busy_done", busy, 0);
    chk("sd_rd_done", sd_rd, 0);
    chk("wr_count", wlog_addr.size(), WORDS);
    nw = (wlog_addr.size() < WORDS) ? wlog_addr.size() : WORDS;
    for (int w = 0; w < nw; w++) begin
      ew = '0;
      for (int l = 0; l < PPW; l++) ew = (ew << 8) | DW'(img_q[w * PPW + l]);
      chk("wr_addr", wlog_addr[w], w);
      chk("wr_data", wlog_data[w], ew);
    end
    for (int i = 0; i < BYTES; i++) ref_img[i] = img_q[i];
    model_loaded = 1'b1;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    pat[0] = 8'hE0; pat[1] = 8'h1C; pat[2] = 8'h03; pat[3] = 8'hFF;
    dir_exp[0] = 12'hE00; dir_exp[1] = 12'h0E0; dir_exp[2] = 12'h00C; dir_exp[3] = 12'hEEC;
    rst = 1'b1; start = 1'b0; imno = '0; sd_ready_for_read = 1'b1;
    sd_byte_available = 1'b0; sd_byte = 8'h00; x = 10'd0; y = 10'd0;
    model_loaded = 1'b0;
    tick(3);
    chk("rst_sd_rd", sd_rd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_loaded", loaded, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_sd_address", sd_address, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_rgb", {red, green, blue}, 12'hFFF);
    rst = 1'b0;
    tick(1);
    run_pixels(4, 1'b0);

    // Image 0 with a known first word, then directed and random readout.
    pulse_start(0);
    serve_load(0, 1'b1, 1'b0);
    run_pixels(4, 1'b1);
    run_pixels(40, 1'b0);

    // Reload image 2: white while reloading, start pulses ignored while busy.
    pulse_start(2);
    model_loaded = 1'b0;
    run_pixels(3, 1'b0);
    serve_load(2, 1'b0, 1'b1);
    run_pixels(40, 1'b0);

    // Reset in the middle of a sector, then a clean reload.
    pulse_start(1);
    model_loaded = 1'b0;
    img_q.delete();
    serve_sector(1, 0, 1'b0, 1'b0, 100);
    rst = 1'b1; sd_byte_available = 1'b0;
    tick(1);
    chk("midrst_sd_rd", sd_rd, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_loaded", loaded, 0);
    chk("midrst_wr_en", wr_en, 0);
    chk("midrst_rgb", {red, green, blue}, 12'hFFF);
    rst = 1'b0; sd_ready_for_read = 1'b1;
    tick(2);
    chk("idle_no_request", sd_rd, 0);
    pulse_start(3);
    serve_load(3, 1'b0, 1'b0);
    run_pixels(20, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
